// File: rtl/playlist_ctrl_if.sv
// Button/mode inputs and player-control outputs of the playlist controller.
// The master modport is the button front end; the slave modport is the controller.
interface playlist_ctrl_if #(
  parameter int SONG_BITS = 2
);
  logic                 play_pause;
  logic                 next;
  logic                 prev;
  logic [1:0]           mode;
  logic                 song_done;
  logic [SONG_BITS-1:0] song;
  logic                 play;
  logic                 reset_play;
  logic                 stopped;

  modport master (
    output play_pause, next, prev, mode, song_done,
    input  song, play, reset_play, stopped
  );

  modport slave (
    input  play_pause, next, prev, mode, song_done,
    output song, play, reset_play, stopped
  );
endinterface

// File: rtl/playlist_ctrl.sv
// Playlist sequencer: song index, play/pause state and reader clear pulse.
// Define PLAYLIST_GAP_EN to insert GAP_CYCLES of silence after each auto-advance.
module playlist_ctrl #(
  parameter int NUM_SONGS  = 4,
  parameter int SONG_BITS  = 2,
  parameter int CLR_CYCLES = 2,
  parameter int GAP_CYCLES = 16
) (
  input  logic          clk,
  input  logic          reset,
  playlist_ctrl_if.slave bus
);

  localparam int CNT_MAX = (GAP_CYCLES > CLR_CYCLES) ? GAP_CYCLES : CLR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [SONG_BITS-1:0] LAST_SONG = SONG_BITS'(NUM_SONGS - 1);
  localparam logic [CNT_W-1:0]     CLR_LAST  = CNT_W'(CLR_CYCLES - 1);
`ifdef PLAYLIST_GAP_EN
  localparam logic [CNT_W-1:0]     GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_CLR,
    S_PAUSED,
    S_PLAYING,
    S_STOP
`ifdef PLAYLIST_GAP_EN
    , S_GAP
`endif
  } state_t;

  // Where an auto-advance lands once the clear pulse is over.
`ifdef PLAYLIST_GAP_EN
  localparam state_t DONE_TGT = S_GAP;
`else
  localparam state_t DONE_TGT = S_PLAYING;
`endif

  state_t               state_q, state_d;
  state_t               target_q, target_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SONG_BITS-1:0] song_q, song_d;
  logic                 play_q, play_d;
  logic                 reset_play_q, reset_play_d;
  logic                 stopped_q, stopped_d;

  logic                 one_track;
  logic [SONG_BITS-1:0] song_inc, song_dec, song_track;
  logic                 clr_go;
  state_t               clr_tgt;

  assign one_track  = bus.next ^ bus.prev;
  assign song_inc   = (song_q == LAST_SONG) ? '0 : song_q + SONG_BITS'(1);
  assign song_dec   = (song_q == '0) ? LAST_SONG : song_q - SONG_BITS'(1);
  assign song_track = bus.next ? song_inc : song_dec;

  // NOTE: every signal written here gets a default first so no path infers a latch.
  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    cnt_d        = cnt_q;
    song_d       = song_q;
    play_d       = play_q;
    reset_play_d = reset_play_q;
    stopped_d    = stopped_q;
    clr_go       = 1'b0;
    clr_tgt      = S_PAUSED;

    unique case (state_q)
      S_CLR: begin
        if (cnt_q == CLR_LAST) begin
          state_d      = target_q;
          cnt_d        = '0;
          reset_play_d = 1'b0;
          play_d       = (target_q == S_PLAYING);
          stopped_d    = (target_q == S_STOP);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PAUSED: begin
        if (one_track) begin
          song_d  = song_track;
          clr_go  = 1'b1;
          clr_tgt = S_PAUSED;
        end else if (bus.play_pause) begin
          state_d = S_PLAYING;
          play_d  = 1'b1;
        end
      end
      S_PLAYING: begin
        if (one_track) begin
          song_d  = song_track;
          clr_go  = 1'b1;
          clr_tgt = S_PLAYING;
        end else if (bus.song_done) begin
          clr_go  = 1'b1;
          clr_tgt = DONE_TGT;
          if (bus.mode != 2'b10) song_d = song_inc;
          if (bus.mode == 2'b00 && song_q == LAST_SONG) clr_tgt = S_STOP;
        end else if (bus.play_pause) begin
          state_d = S_PAUSED;
          play_d  = 1'b0;
        end
      end
      S_STOP: begin
        if (one_track) begin
          song_d  = song_track;
          clr_go  = 1'b1;
          clr_tgt = S_PAUSED;
        end else if (bus.play_pause) begin
          song_d  = '0;
          clr_go  = 1'b1;
          clr_tgt = S_PLAYING;
        end
      end
`ifdef PLAYLIST_GAP_EN
      S_GAP: begin
        if (one_track) begin
          song_d  = song_track;
          clr_go  = 1'b1;
          clr_tgt = S_PLAYING;
        end else if (bus.play_pause) begin
          state_d = S_PAUSED;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = S_PLAYING;
          cnt_d   = '0;
          play_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = S_CLR;
    endcase

    if (clr_go) begin
      state_d      = S_CLR;
      target_d     = clr_tgt;
      cnt_d        = '0;
      play_d       = 1'b0;
      reset_play_d = 1'b1;
      stopped_d    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous, sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_CLR;
      target_q     <= S_PAUSED;
      cnt_q        <= '0;
      song_q       <= '0;
      play_q       <= 1'b0;
      reset_play_q <= 1'b1;
      stopped_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      cnt_q        <= cnt_d;
      song_q       <= song_d;
      play_q       <= play_d;
      reset_play_q <= reset_play_d;
      stopped_q    <= stopped_d;
    end
  end

  assign bus.song       = song_q;
  assign bus.play       = play_q;
  assign bus.reset_play = reset_play_q;
  assign bus.stopped    = stopped_q;

endmodule
